// File: rtl/picosoc_iomem_fabric.sv
// iomem fan-out fabric: decodes the CPU iomem request into NSLAVES power-of-two windows,
// registers request/response, and aborts stalled or unmapped accesses with a sticky irq.
module picosoc_iomem_fabric #(
  parameter int unsigned NSLAVES    = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int unsigned SLOT_SHIFT = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_RDATA  = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [3:0]             m_wstrb,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  output logic [31:0]            m_rdata,
  output logic [NSLAVES-1:0]     s_valid,
  input  logic [NSLAVES-1:0]     s_ready,
  output logic [3:0]             s_wstrb,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  input  logic [32*NSLAVES-1:0]  s_rdata,
  output logic                   irq_stall,
  input  logic                   irq_ack,
  output logic [31:0]            err_addr
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state, state_n;
  logic [SW-1:0]        slot, slot_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 m_ready_n;
  logic [31:0]          m_rdata_n;
  logic [NSLAVES-1:0]   s_valid_n;
  logic [31:0]          s_addr_n, s_wdata_n, err_addr_n;
  logic [3:0]           s_wstrb_n;
  logic                 irq_set;
  logic [31:0]          off, off_slot;
  logic                 mapped;
  logic [SW-1:0]        dec_slot;
  logic [31:0]          rdata_arr [NSLAVES];

  assign off      = m_addr - BASE_ADDR;
  assign off_slot = off >> SLOT_SHIFT;
  assign mapped   = (m_addr >= BASE_ADDR) && (off_slot < 32'(NSLAVES));
  assign dec_slot = SW'(off_slot);

  for (genvar i = 0; i < NSLAVES; i++) begin : g_rdata
    assign rdata_arr[i] = s_rdata[32*i +: 32];
  end

  always_comb begin
    state_n    = state;
    slot_n     = slot;
    cnt_n      = cnt;
    m_ready_n  = 1'b0;
    m_rdata_n  = m_rdata;
    s_valid_n  = s_valid;
    s_addr_n   = s_addr;
    s_wdata_n  = s_wdata;
    s_wstrb_n  = s_wstrb;
    err_addr_n = err_addr;
    irq_set    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (m_valid) begin
          if (mapped) begin
            slot_n              = dec_slot;
            s_valid_n           = '0;
            s_valid_n[dec_slot] = 1'b1;
            s_addr_n            = m_addr;
            s_wdata_n           = m_wdata;
            s_wstrb_n           = m_wstrb;
            state_n             = ACCESS;
          end else begin
            m_rdata_n  = ERR_RDATA;
            err_addr_n = m_addr;
            irq_set    = 1'b1;
            m_ready_n  = 1'b1;
            state_n    = RESP;
          end
        end
      end
      ACCESS: begin
        // Saturating: the counter must never wrap back under the abort threshold.
        if (cnt != '1) cnt_n = cnt + 1'b1;
        if (s_ready[slot]) begin
          m_rdata_n = rdata_arr[slot];
          s_valid_n = '0;
          m_ready_n = 1'b1;
          state_n   = RESP;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
          m_rdata_n  = ERR_RDATA;
          err_addr_n = s_addr;
          irq_set    = 1'b1;
          s_valid_n  = '0;
          m_ready_n  = 1'b1;
          state_n    = RESP;
        end
      end
      RESP: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      slot      <= '0;
      cnt       <= '0;
      m_ready   <= 1'b0;
      m_rdata   <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      irq_stall <= 1'b0;
      err_addr  <= '0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      cnt       <= cnt_n;
      m_ready   <= m_ready_n;
      m_rdata   <= m_rdata_n;
      s_valid   <= s_valid_n;
      s_addr    <= s_addr_n;
      s_wdata   <= s_wdata_n;
      s_wstrb   <= s_wstrb_n;
      irq_stall <= irq_set | (irq_stall & ~irq_ack);
      err_addr  <= err_addr_n;
    end
  end

endmodule
